// File: rtl/design_sel_pkg.sv
// Shared constants and state type for the design-select switch controller.
// The controller hands the shared GPIO pads from one student design to another.
package design_sel_pkg;

  localparam int NUM_DESIGNS = 12;
  localparam int GPIO_W      = 34;
  localparam int SEL_NONE    = 0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    GUARD  = 2'd2,
    ENABLE = 2'd3
  } sw_state_t;

endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchroniser plus stability counter for the raw design-select pads.
// A new code is accepted only after it has been seen unchanged for STABLE_CYCLES comparisons.
module sel_debounce
  import design_sel_pkg::*;
#(
  parameter int SEL_W         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] design_select_in,
  output logic [SEL_W-1:0] debounced_sel
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [SEL_W-1:0] sync1_r;
  logic [SEL_W-1:0] sync2_r;
  logic [SEL_W-1:0] prev_r;
  logic [SEL_W-1:0] deb_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next stability count: saturating run length of identical synchronised samples.
  always_comb begin
    cnt_next_s = '0;
    if (sync2_r == prev_r) begin
      if (cnt_r == CNT_W'(STABLE_CYCLES)) begin
        cnt_next_s = cnt_r;
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_next_s = '0;
    end
  end

  // Synchroniser, sample history, counter and accepted code.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      prev_r  <= '0;
      cnt_r   <= '0;
      deb_r   <= '0;
    end else begin
      sync1_r <= design_select_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      cnt_r   <= cnt_next_s;
      if (cnt_next_s == CNT_W'(STABLE_CYCLES)) begin
        deb_r <= sync2_r;
      end else begin
        deb_r <= deb_r;
      end
    end
  end

  assign debounced_sel = deb_r;

endmodule

// File: rtl/design_switch_ctrl.sv
// Pad-ownership sequencer: on every accepted select change, deselect everything,
// hold the pads tristated for a guard interval, then chip-select the new design.
module design_switch_ctrl
  import design_sel_pkg::*;
#(
  parameter int NUM_DESIGNS   = 12,
  parameter int SEL_W         = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int GUARD_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       design_select_in,
  output logic [SEL_W-1:0]       active_sel,
  output logic [NUM_DESIGNS-1:0] designs_ncs,
  output logic                   gpio_force_input,
  output logic                   busy,
  output logic                   switch_done,
  output logic                   sel_err
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  sw_state_t              state_r;
  logic [SEL_W-1:0]       target_r;
  logic [GW-1:0]          guard_cnt_r;
  logic [SEL_W-1:0]       deb_s;
  logic [SEL_W-1:0]       mapped_s;
  logic                   sel_err_s;
  logic [NUM_DESIGNS-1:0] ncs_dec_s;

  sel_debounce #(
    .SEL_W         (SEL_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sel_debounce (
    .clk              (clk),
    .rst              (rst),
    .design_select_in (design_select_in),
    .debounced_sel    (deb_s)
  );

  // Out-of-range codes select nothing and raise the error flag.
  always_comb begin
    mapped_s  = deb_s;
    sel_err_s = 1'b0;
    if (deb_s > SEL_W'(NUM_DESIGNS)) begin
      mapped_s  = SEL_W'(SEL_NONE);
      sel_err_s = 1'b1;
    end else begin
      mapped_s  = deb_s;
      sel_err_s = 1'b0;
    end
  end

  // One-cold chip-select decode of the latched target; target 0 leaves all high.
  always_comb begin
    ncs_dec_s = '1;
    for (int i = 0; i < NUM_DESIGNS; i++) begin
      if (target_r == SEL_W'(i + 1)) begin
        ncs_dec_s[i] = 1'b0;
      end else begin
        ncs_dec_s[i] = 1'b1;
      end
    end
  end

  // Switch FSM with registered outputs; ENABLE values persist through RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= RUN;
      target_r         <= '0;
      guard_cnt_r      <= '0;
      active_sel       <= '0;
      designs_ncs      <= '1;
      gpio_force_input <= 1'b1;
      busy             <= 1'b0;
      switch_done      <= 1'b0;
      sel_err          <= 1'b0;
    end else begin
      sel_err <= sel_err_s;
      case (state_r)
        RUN: begin
          switch_done <= 1'b0;
          if (mapped_s != active_sel) begin
            target_r         <= mapped_s;
            state_r          <= DRAIN;
            active_sel       <= '0;
            designs_ncs      <= '1;
            gpio_force_input <= 1'b1;
            busy             <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        DRAIN: begin
          guard_cnt_r <= GW'(GUARD_CYCLES - 1);
          state_r     <= GUARD;
        end
        GUARD: begin
          if (guard_cnt_r == '0) begin
            state_r          <= ENABLE;
            active_sel       <= target_r;
            designs_ncs      <= ncs_dec_s;
            gpio_force_input <= (target_r == SEL_W'(SEL_NONE));
            switch_done      <= 1'b1;
          end else begin
            guard_cnt_r <= guard_cnt_r - GW'(1);
          end
        end
        ENABLE: begin
          state_r     <= RUN;
          busy        <= 1'b0;
          switch_done <= 1'b0;
        end
        default: begin
          state_r          <= RUN;
          active_sel       <= '0;
          designs_ncs      <= '1;
          gpio_force_input <= 1'b1;
          busy             <= 1'b0;
          switch_done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_design_switch_ctrl.sv
// Self-checking bench: directed scenarios plus random pad activity, compared every
// cycle against a window-based debounce model and a countdown-based switch model.
module tb_design_switch_ctrl;

  localparam int ND    = 12;
  localparam int GUARD = 16;
  localparam int INV   = 99;

  logic        clk;
  logic        rst;
  logic [3:0]  pad;
  logic [3:0]  active_sel;
  logic [11:0] designs_ncs;
  logic        gpio_force_input;
  logic        busy;
  logic        switch_done;
  logic        sel_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state
  int m_active, m_target, m_deb, m_left;
  bit m_busy, m_done, m_err, m_valid;
  int hist[$];

  design_switch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .design_select_in (pad),
    .active_sel       (active_sel),
    .designs_ncs      (designs_ncs),
    .gpio_force_input (gpio_force_input),
    .busy             (busy),
    .switch_done      (switch_done),
    .sel_err          (sel_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] ncs_of(input int a);
    logic [11:0] one;
    one = 12'h001;
    if (a == 0) return 12'hFFF;
    return ~(one << (a - 1));
  endfunction

  // Model: a code is accepted once the pad held it for 5 consecutive samples,
  // visible two edges later; a switch takes GUARD+1 edges from detect to enable.
  task automatic model_step(input logic r, input int p);
    int  tgt;
    bit  same;
    if (r) begin
      m_active = 0; m_target = 0; m_deb = 0; m_left = 0;
      m_busy = 0; m_done = 0; m_err = 0; m_valid = 1;
      hist = {INV, 0, 0, 0};
    end else if (m_valid) begin
      tgt   = (m_deb > ND) ? 0 : m_deb;
      m_err = (m_deb > ND);
      if (m_left == 0) begin
        m_done = 0;
        if (tgt != m_active) begin
          m_target = tgt; m_active = 0; m_busy = 1; m_left = GUARD + 2;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_left--;
        if (m_left == 1) begin
          m_active = m_target; m_done = 1;
        end else if (m_left == 0) begin
          m_done = 0; m_busy = 0;
        end
      end
      hist.push_back(p);
      if (hist.size() > 7) void'(hist.pop_front());
      if (hist.size() == 7) begin
        same = 1;
        for (int i = 1; i < 5; i++) if (hist[i] != hist[0]) same = 0;
        if (same && hist[0] != INV) m_deb = hist[0];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(rst, int'(pad));
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      chk("active_sel", 32'(active_sel), 32'(m_active));
      chk("designs_ncs", 32'(designs_ncs), 32'(ncs_of(m_active)));
      chk("gpio_force_input", 32'(gpio_force_input), 32'(m_active == 0));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("switch_done", 32'(switch_done), 32'(m_done));
      chk("sel_err", 32'(sel_err), 32'(m_err));
      chk("one_hot_ncs", 32'($countones(~designs_ncs) <= 1), 32'd1);
    end
  endtask

  initial begin
    int cnt;
    m_valid = 0;
    rst = 1'b1;
    pad = 4'd0;
    step();
    step();
    chk("reset_ncs", 32'(designs_ncs), 32'h0FFF);
    chk("reset_force", 32'(gpio_force_input), 32'd1);
    rst = 1'b0;

    // idle at select 0
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (switch_done) cnt++;
    end
    chk("idle_no_done", 32'(cnt), 32'd0);
    chk("idle_ncs", 32'(designs_ncs), 32'h0FFF);
    chk("idle_busy", 32'(busy), 32'd0);

    // 0 -> 3, switch_done exactly 25 cycles after the change
    pad = 4'd3;
    repeat (24) step();
    chk("s3_done_early", 32'(switch_done), 32'd0);
    chk("s3_busy_before", 32'(busy), 32'd1);
    step();
    chk("s3_done", 32'(switch_done), 32'd1);
    chk("s3_ncs", 32'(designs_ncs), 32'h0FFB);
    chk("s3_force", 32'(gpio_force_input), 32'd0);
    chk("s3_active", 32'(active_sel), 32'd3);
    repeat (5) step();

    // 3 -> 7: deselected window is DRAIN + GUARD = 17 cycles
    pad = 4'd7;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (designs_ncs == 12'hFFF && gpio_force_input) cnt++;
    end
    chk("s7_gap_len", 32'(cnt), 32'd17);
    chk("s7_ncs", 32'(designs_ncs), 32'h0FBF);
    chk("s7_active", 32'(active_sel), 32'd7);

    // back to 3, then a 2-cycle glitch to 5 must not start a sequence
    pad = 4'd3;
    repeat (30) step();
    pad = 4'd5;
    step(); step();
    pad = 4'd3;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (busy) cnt++;
    end
    chk("glitch_no_busy", 32'(cnt), 32'd0);
    chk("glitch_active", 32'(active_sel), 32'd3);

    // out-of-range code 14
    pad = 4'd14;
    repeat (30) step();
    chk("err_flag", 32'(sel_err), 32'd1);
    chk("err_active", 32'(active_sel), 32'd0);
    chk("err_ncs", 32'(designs_ncs), 32'h0FFF);

    // 0 -> 2, then 9 during the guard interval
    pad = 4'd0;
    repeat (10) step();
    pad = 4'd2;
    repeat (13) step();
    pad = 4'd9;
    repeat (12) step();
    chk("two_first_done", 32'(switch_done), 32'd1);
    chk("two_first_active", 32'(active_sel), 32'd2);
    repeat (25) step();
    chk("two_second_active", 32'(active_sel), 32'd9);
    chk("two_second_ncs", 32'(designs_ncs), 32'h0EFF);

    // reset in the middle of the guard interval
    pad = 4'd3;
    repeat (16) step();
    rst = 1'b1;
    step();
    chk("rst_mid_ncs", 32'(designs_ncs), 32'h0FFF);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_active", 32'(active_sel), 32'd0);
    rst = 1'b0;
    repeat (24) step();
    chk("rst_fresh_ncs", 32'(designs_ncs), 32'h0FFF);
    step();
    chk("rst_fresh_done", 32'(switch_done), 32'd1);
    chk("rst_fresh_ncs2", 32'(designs_ncs), 32'h0FFB);

    // random pad activity with occasional resets
    for (int b = 0; b < 60; b++) begin
      pad = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) rst = 1'b1;
      step();
      rst = 1'b0;
      repeat ($urandom_range(0, 35)) step();
    end
    repeat (40) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
